// File: rtl/cdb_arbiter_if.sv
// Producer-side request bus and CDB broadcast bundle for cdb_arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned DATA_W   = 32
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ROB_ID_W-1:0] req_rob_id;
  logic [NUM_REQ*DATA_W-1:0]   req_value;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        cdb_ready;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [DATA_W-1:0]           cdb_value;
  logic [2:0]                  cdb_src;
  logic                        busy;

  modport master (
    output req_valid, req_rob_id, req_value,
    input  req_ready, cdb_ready, cdb_rob_id, cdb_value, cdb_src, busy
  );

  modport slave (
    input  req_valid, req_rob_id, req_value,
    output req_ready, cdb_ready, cdb_rob_id, cdb_value, cdb_src, busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Shares the ROB's ALU-side CDB write port among NUM_REQ producers:
// per-producer 2-entry FIFOs drained one per cycle by a round-robin scheduler.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear_in,
  cdb_arbiter_if.slave bus
);

  logic [ROB_ID_W-1:0] q_id  [NUM_REQ][2];
  logic [DATA_W-1:0]   q_val [NUM_REQ][2];
  logic                q_rd  [NUM_REQ];
  logic                q_wr  [NUM_REQ];
  logic [1:0]          q_cnt [NUM_REQ];

  logic [2:0]          rr_ptr;
  logic                cdb_ready_q;
  logic [ROB_ID_W-1:0] cdb_id_q;
  logic [DATA_W-1:0]   cdb_val_q;
  logic [2:0]          cdb_src_q;

  logic                active;
  logic [NUM_REQ-1:0]  nonempty;
  logic [NUM_REQ-1:0]  req_ready_w;
  logic [NUM_REQ-1:0]  push;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                grant_valid;
  logic [2:0]          grant_idx;
  logic [2:0]          rr_next;
  logic [ROB_ID_W-1:0] head_id;
  logic [DATA_W-1:0]   head_val;

  assign active = rdy_in & ~clear_in;

  // Readiness depends only on the registered count, never on this cycle's pop.
  always_comb begin
    nonempty    = '0;
    req_ready_w = '0;
    push        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      nonempty[i]    = (q_cnt[i] != 2'd0);
      req_ready_w[i] = active & (q_cnt[i] != 2'd2);
      push[i]        = bus.req_valid[i] & req_ready_w[i];
    end
  end

  // Rotating priority as two linear scans: [rr_ptr..N-1], then [0..rr_ptr-1].
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    head_id     = '0;
    head_val    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && (k >= 32'(rr_ptr)) && nonempty[k]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && (k < 32'(rr_ptr)) && nonempty[k]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_valid && (grant_idx == 3'(k))) begin
        grant_oh[k] = 1'b1;
        head_id     = q_id[k][q_rd[k]];
        head_val    = q_val[k][q_rd[k]];
      end
    end
  end

  assign rr_next = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;

  // Queue pointers and occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        q_rd[i]  <= 1'b0;
        q_wr[i]  <= 1'b0;
        q_cnt[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          q_rd[i]  <= 1'b0;
          q_wr[i]  <= 1'b0;
          q_cnt[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (push[i])
            q_wr[i] <= ~q_wr[i];
          if (grant_oh[i])
            q_rd[i] <= ~q_rd[i];
          case ({push[i], grant_oh[i]})
            2'b10:   q_cnt[i] <= q_cnt[i] + 2'd1;
            2'b01:   q_cnt[i] <= q_cnt[i] - 2'd1;
            default: q_cnt[i] <= q_cnt[i];
          endcase
        end
      end
    end
  end

  // Payload storage; stale slots are harmless because q_cnt governs validity.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        q_id[i][q_wr[i]]  <= bus.req_rob_id[i*ROB_ID_W +: ROB_ID_W];
        q_val[i][q_wr[i]] <= bus.req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered broadcast and scheduler pointer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr      <= '0;
      cdb_ready_q <= 1'b0;
      cdb_id_q    <= '0;
      cdb_val_q   <= '0;
      cdb_src_q   <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        rr_ptr      <= '0;
        cdb_ready_q <= 1'b0;
      end else if (grant_valid) begin
        rr_ptr      <= rr_next;
        cdb_ready_q <= 1'b1;
        cdb_id_q    <= head_id;
        cdb_val_q   <= head_val;
        cdb_src_q   <= grant_idx;
      end else begin
        cdb_ready_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.cdb_ready  = cdb_ready_q;
  assign bus.cdb_rob_id = cdb_id_q;
  assign bus.cdb_value  = cdb_val_q;
  assign bus.cdb_src    = cdb_src_q;
  assign bus.busy       = cdb_ready_q | (|nonempty);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-producer feeder plus broadcast scoreboard.
module tb_cdb_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ROB_ID_W = 5;
  localparam int unsigned DATA_W   = 32;

  typedef struct {
    int          p;
    logic [4:0]  id;
    logic [31:0] val;
  } ent_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  ent_t pend_q[$];
  ent_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int p, input logic [4:0] id, input logic [31:0] val);
    ent_t e;
    e.p = p; e.id = id; e.val = val;
    pend_q.push_back(e);
  endtask

  // Each producer offers its oldest not-yet-accepted item.
  task automatic present();
    logic [NUM_REQ-1:0] v;
    v = '0;
    bus.req_rob_id = '0;
    bus.req_value  = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      for (int j = 0; j < pend_q.size(); j++) begin
        if (!v[p] && pend_q[j].p == p) begin
          v[p] = 1'b1;
          bus.req_rob_id[p*ROB_ID_W +: ROB_ID_W] = pend_q[j].id;
          bus.req_value[p*DATA_W +: DATA_W]      = pend_q[j].val;
        end
      end
    end
    bus.req_valid = v;
  endtask

  task automatic sb_check();
    int idx;
    idx = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (idx < 0 && exp_q[j].p == int'(bus.cdb_src)) idx = j;
    checks++;
    assert (idx >= 0) else begin
      errors++;
      $error("FAIL sb_unexpected: observed src=%0d id=%0d expected no broadcast", bus.cdb_src, bus.cdb_rob_id);
    end
    if (idx >= 0) begin
      check("sb_id", 32'(bus.cdb_rob_id), 32'(exp_q[idx].id));
      check("sb_val", bus.cdb_value, exp_q[idx].val);
      exp_q.delete(idx);
    end
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    logic was_rdy, was_clr, found;
    present();
    @(negedge clk_in);
    acc     = bus.req_valid & bus.req_ready;
    was_rdy = rdy_in;
    was_clr = clear_in;
    if (was_rdy && !was_clr) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        found = 1'b0;
        for (int j = 0; j < pend_q.size(); j++) begin
          if (acc[p] && !found && pend_q[j].p == p) begin
            found = 1'b1;
            exp_q.push_back(pend_q[j]);
            pend_q.delete(j);
          end
        end
      end
    end
    @(posedge clk_in);
    #1;
    if (was_rdy && was_clr) exp_q.delete();
    else if (was_rdy && bus.cdb_ready) sb_check();
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && (pend_q.size() != 0 || exp_q.size() != 0 || bus.busy); n++) tick();
    check({tag, "_left"}, 32'(pend_q.size() + exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    bus.req_valid = '0; bus.req_rob_id = '0; bus.req_value = '0;

    // Reset values
    #12;
    check("rst_cdb_ready", 32'(bus.cdb_ready), 32'd0);
    check("rst_rob_id", 32'(bus.cdb_rob_id), 32'd0);
    check("rst_value", bus.cdb_value, 32'd0);
    check("rst_src", 32'(bus.cdb_src), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'hf);

    // Single push: two-cycle latency, no bypass
    add(2, 5'd5, 32'h1234);
    tick();
    check("t1_no_bypass", 32'(bus.cdb_ready), 32'd0);
    check("t1_busy_queued", 32'(bus.busy), 32'd1);
    tick();
    check("t1_cdb_ready", 32'(bus.cdb_ready), 32'd1);
    check("t1_rob_id", 32'(bus.cdb_rob_id), 32'd5);
    check("t1_value", bus.cdb_value, 32'h1234);
    check("t1_src", 32'(bus.cdb_src), 32'd2);
    tick();
    check("t1_idle", 32'(bus.cdb_ready), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);

    // Fairness with all queues kept full
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 4; k++)
        add(p, 5'(p*4 + k + 1), 32'hA500_0000 + 32'(p*4 + k + 1));
    tick();
    check("t2_first_idle", 32'(bus.cdb_ready), 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t2_ready", 32'(bus.cdb_ready), 32'd1);
      check("t2_src", 32'(bus.cdb_src), 32'(k % 4));
    end
    tick();
    check("t2_done", 32'(bus.cdb_ready), 32'd0);
    check("t2_left", 32'(pend_q.size() + exp_q.size()), 32'd0);

    // Full queue: producer 1 fills while producer 0 wins first
    add(0, 5'd17, 32'hB000_0011); add(0, 5'd18, 32'hB000_0012); add(0, 5'd19, 32'hB000_0013);
    add(1, 5'd7, 32'hB100_0007);  add(1, 5'd8, 32'hB100_0008);  add(1, 5'd9, 32'hB100_0009);
    tick();
    tick();
    check("t3_src0", 32'(bus.cdb_src), 32'd0);
    check("t3_full_ready", 32'(bus.req_ready), 32'b1101);
    tick();
    check("t3_src1", 32'(bus.cdb_src), 32'd1);
    check("t3_pop_no_push", 32'(bus.req_ready), 32'b1110);
    drain("t3");

    // Flush with three queued entries and a live broadcast
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    add(1, 5'd10, 32'hC100_000A); add(1, 5'd11, 32'hC100_000B);
    add(2, 5'd12, 32'hC200_000C); add(2, 5'd13, 32'hC200_000D);
    tick();
    tick();
    check("t4_pre_ready", 32'(bus.cdb_ready), 32'd1);
    check("t4_pre_src", 32'(bus.cdb_src), 32'd1);
    clear_in = 1'b1;
    add(3, 5'd20, 32'hC300_0014);
    tick();
    check("t4_clr_ready", 32'(bus.cdb_ready), 32'd0);
    check("t4_clr_busy", 32'(bus.busy), 32'd0);
    check("t4_clr_req_ready", 32'(bus.req_ready), 32'd0);
    clear_in = 1'b0;
    #1;
    check("t4_req_ready", 32'(bus.req_ready), 32'hf);
    add(1, 5'd22, 32'hC100_0016);
    tick();
    check("t4_latency", 32'(bus.cdb_ready), 32'd0);
    tick();
    check("t4_rr_src", 32'(bus.cdb_src), 32'd1);
    tick();
    check("t4_p3_src", 32'(bus.cdb_src), 32'd3);
    check("t4_p3_id", 32'(bus.cdb_rob_id), 32'd20);
    drain("t4");

    // Pause holds the broadcast and the queues
    add(0, 5'd9, 32'hD000_0009); add(0, 5'd10, 32'hD000_000A); add(0, 5'd11, 32'hD000_000B);
    tick();
    tick();
    check("t5_pre_id", 32'(bus.cdb_rob_id), 32'd9);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_hold_ready", 32'(bus.cdb_ready), 32'd1);
      check("t5_hold_id", 32'(bus.cdb_rob_id), 32'd9);
      check("t5_req_ready", 32'(bus.req_ready), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check("t5_resume_id10", 32'(bus.cdb_rob_id), 32'd10);
    tick();
    check("t5_resume_id11", 32'(bus.cdb_rob_id), 32'd11);
    drain("t5");

    // Asynchronous reset between edges
    add(2, 5'd3, 32'hE200_0003); add(2, 5'd4, 32'hE200_0004); add(2, 5'd6, 32'hE200_0006);
    tick();
    tick();
    check("t6_pre_ready", 32'(bus.cdb_ready), 32'd1);
    pend_q.delete();
    present();
    #1 rst_in = 1'b1;
    #1;
    check("t6_rst_ready", 32'(bus.cdb_ready), 32'd0);
    check("t6_rst_id", 32'(bus.cdb_rob_id), 32'd0);
    check("t6_rst_value", bus.cdb_value, 32'd0);
    check("t6_rst_src", 32'(bus.cdb_src), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    rst_in = 1'b0;
    #1;
    check("t6_req_ready", 32'(bus.req_ready), 32'hf);
    add(0, 5'd30, 32'hE000_001E);
    tick();
    tick();
    check("t6_post_src", 32'(bus.cdb_src), 32'd0);
    check("t6_post_id", 32'(bus.cdb_rob_id), 32'd30);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no completion expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
